// File: rtl/ps2_receiver.sv
// Receive-only PS/2 port: synchronises and glitch-filters the pins, decodes
// 11-bit frames and buffers good bytes in a show-ahead FIFO with sticky errors.
module ps2_receiver #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] TIMEOUT    = 16'd40000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  input  logic       read_strobe,
  input  logic       flush,
  input  logic       status_clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overflow,
  output logic       irq
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     LP_FULL    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     LP_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]   LP_PTR_ONE = AW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clock_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_in;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Filtered clock flips on the 4th consecutive sample that disagrees with it.
  logic [1:0] r_filt_cnt;
  logic       r_filt_clk;
  logic       w_filt_flip, w_sample;

  assign w_filt_flip = (r_clk_s2 != r_filt_clk) && (r_filt_cnt == 2'd3);
  assign w_sample    = w_filt_flip && r_filt_clk;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_filt_cnt <= 2'd0;
      r_filt_clk <= 1'b1;
    end else if (r_clk_s2 == r_filt_clk) begin
      r_filt_cnt <= 2'd0;
    end else if (w_filt_flip) begin
      r_filt_cnt <= 2'd0;
      r_filt_clk <= r_clk_s2;
    end else begin
      r_filt_cnt <= r_filt_cnt + 2'd1;
    end
  end

  logic [1:0]  r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic [15:0] r_to_cnt;
  logic        w_timeout, w_stop_evt, w_par_ok, w_push, w_set_perr, w_set_ferr;

  assign w_timeout  = (r_state != S_IDLE) && (r_to_cnt == TIMEOUT) && !w_sample;
  assign w_stop_evt = w_sample && (r_state == S_STOP);
  assign w_par_ok   = ^{r_shift, r_parity};
  assign w_push     = w_stop_evt && w_par_ok && r_dat_s2;
  assign w_set_perr = w_stop_evt && !w_par_ok;
  assign w_set_ferr = w_timeout || (w_stop_evt && w_par_ok && !r_dat_s2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_parity  <= 1'b0;
      r_to_cnt  <= 16'd0;
    end else begin
      if (r_state == S_IDLE || w_sample || w_timeout) r_to_cnt <= 16'd0;
      else                                            r_to_cnt <= r_to_cnt + 16'd1;

      if (w_timeout) begin
        r_state <= S_IDLE;
      end else if (w_sample) begin
        case (r_state)
          S_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            r_shift[r_bit_cnt] <= r_dat_s2;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_parity <= r_dat_s2;
            r_state  <= S_STOP;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop, w_full, w_wr, w_set_ovf;

  assign w_pop     = read_strobe && (r_count != '0);
  assign w_full    = (r_count == LP_FULL);
  assign w_wr      = w_push && (!w_full || w_pop) && !flush;
  assign w_set_ovf = w_push && w_full && !w_pop && !flush;

  // NOTE: the storage array has no reset; an entry is only visible once counted.
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // A flag raised in the same cycle as status_clear stays set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      parity_error  <= w_set_perr | (parity_error  & ~status_clear);
      framing_error <= w_set_ferr | (framing_error & ~status_clear);
      overflow      <= w_set_ovf  | (overflow      & ~status_clear);
    end
  end

  assign rx_valid = (r_count != '0);
  assign rx_data  = rx_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign irq      = rx_valid;

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: frame-level reference model (byte queue plus sticky
// flags) driven by directed scenarios and randomized frames.
module tb_ps2_receiver;

  localparam int          DEPTH = 8;
  localparam logic [15:0] TMO   = 16'd600;
  localparam int          HALF  = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_clock_in, ps2_data_in;
  logic       read_strobe, flush, status_clear;
  logic [7:0] rx_data;
  logic       rx_valid, parity_error, framing_error, overflow, irq;

  ps2_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .ps2_clock_in  (ps2_clock_in),
    .ps2_data_in   (ps2_data_in),
    .read_strobe   (read_strobe),
    .flush         (flush),
    .status_clear  (status_clear),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overflow      (overflow),
    .irq           (irq)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  byte unsigned m_q[$];
  bit           m_perr, m_ferr, m_ovf;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, 16'(rx_valid), 16'(m_q.size() != 0));
    check({tag, ".irq"},   16'(irq),      16'(m_q.size() != 0));
    check({tag, ".data"},  16'(rx_data),  16'(m_q.size() != 0 ? m_q[0] : 8'h00));
    check({tag, ".perr"},  16'(parity_error),  16'(m_perr));
    check({tag, ".ferr"},  16'(framing_error), 16'(m_ferr));
    check({tag, ".ovf"},   16'(overflow),      16'(m_ovf));
  endtask

  // Outcome of one complete frame, from the frame rules alone.
  function automatic void model_frame(input byte unsigned d, input bit par, input bit stop,
                                      input bit pop);
    if (pop && m_q.size() != 0) void'(m_q.pop_front());
    if ((^d ^ par) != 1'b1)       m_perr = 1'b1;
    else if (!stop)               m_ferr = 1'b1;
    else if (m_q.size() == DEPTH) m_ovf  = 1'b1;
    else                          m_q.push_back(d);
  endfunction

  task automatic high_phase(input bit glitch);
    if (glitch) begin
      tick(5);
      ps2_clock_in = 1'b0;
      tick(3);
      ps2_clock_in = 1'b1;
      tick(HALF - 8);
    end else begin
      tick(HALF);
    end
  endtask

  task automatic send_bit(input bit b, input bit glitch);
    ps2_data_in = b;
    high_phase(glitch);
    ps2_clock_in = 1'b0;
    tick(HALF);
    ps2_clock_in = 1'b1;
  endtask

  // The stop-bit sample event falls in the cycle after the 5th rising edge
  // past the pin fall, so a pop raised there lands on the push cycle.
  task automatic send_frame(input byte unsigned d, input bit par, input bit stop,
                            input logic [10:0] gmask, input bit pop, input bit lat_chk);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i], gmask[i]);
    ps2_data_in = bits[10];
    high_phase(gmask[10]);
    ps2_clock_in = 1'b0;
    tick(5);
    if (lat_chk) check("lat.pre_valid", 16'(rx_valid), 16'd0);
    read_strobe = pop;
    tick(1);
    read_strobe = 1'b0;
    model_frame(d, par, stop, pop);
    if (lat_chk) check_state("lat.post");
    tick(HALF - 6);
    ps2_clock_in = 1'b1;
    ps2_data_in  = 1'b1;
    tick(4);
  endtask

  task automatic pop_one(input string tag);
    check_state(tag);
    read_strobe = 1'b1;
    tick(1);
    read_strobe = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
    check_state({tag, ".after"});
  endtask

  task automatic clear_flags();
    status_clear = 1'b1;
    tick(1);
    status_clear = 1'b0;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    m_q.delete();
  endtask

  function automatic bit good_par(input byte unsigned d);
    return ~^d;
  endfunction

  initial begin
    byte unsigned d;
    bit           par, stop, pop;
    logic [10:0]  gm;

    reset        = 1'b1;
    ps2_clock_in = 1'b1;
    ps2_data_in  = 1'b1;
    read_strobe  = 1'b0;
    flush        = 1'b0;
    status_clear = 1'b0;
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    tick(3);
    check_state("reset");
    reset = 1'b0;
    tick(5);

    // Basic frame with latency check, then pop back to empty.
    send_frame(8'h1C, 1'b0, 1'b1, 11'h0, 1'b0, 1'b1);
    pop_one("basic.pop");

    // Parity error, then framing error, then clear.
    send_frame(8'h1C, 1'b1, 1'b1, 11'h0, 1'b0, 1'b0);
    check_state("perr");
    send_frame(8'hF0, good_par(8'hF0), 1'b0, 11'h0, 1'b0, 1'b0);
    check_state("ferr");
    clear_flags();
    check_state("clear");

    // Overflow and pointer wrap.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), good_par(8'(i)), 1'b1, 11'h0, 1'b0, 1'b0);
    check_state("ovf.full");
    for (int i = 0; i < 8; i++) pop_one("ovf.pop");
    pop_one("empty.pop");
    clear_flags();
    for (int i = 10; i <= 17; i++) send_frame(8'(i), good_par(8'(i)), 1'b1, 11'h0, 1'b0, 1'b0);
    check_state("wrap.full");
    for (int i = 0; i < 8; i++) pop_one("wrap.pop");

    // Glitches on every bit (start-bit glitch happens with data low).
    send_frame(8'hA5, good_par(8'hA5), 1'b1, 11'h7FF, 1'b0, 1'b0);
    check_state("glitch.frame");
    ps2_data_in = 1'b0;
    tick(4);
    ps2_clock_in = 1'b0;
    tick(3);
    ps2_clock_in = 1'b1;
    tick(10);
    ps2_data_in = 1'b1;
    tick(30);
    check_state("glitch.idle");
    send_frame(8'h3C, good_par(8'h3C), 1'b1, 11'h0, 1'b0, 1'b0);
    check_state("glitch.next");
    do_flush();
    check_state("flush");

    // Timeout after start + 4 data bits.
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data_in = 1'b1;
    tick(int'(TMO) - 40);
    check_state("tmo.pre");
    tick(80);
    m_ferr = 1'b1;
    check_state("tmo");
    send_frame(8'h5A, good_par(8'h5A), 1'b1, 11'h0, 1'b0, 1'b0);
    check_state("tmo.next");
    do_flush();
    clear_flags();

    // Full FIFO with pop on the push cycle.
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      send_frame(d, good_par(d), 1'b1, 11'h0, 1'b0, 1'b0);
    end
    check_state("fullpop.pre");
    send_frame(8'h77, good_par(8'h77), 1'b1, 11'h0, 1'b1, 1'b0);
    check_state("fullpop");
    for (int i = 0; i < DEPTH; i++) pop_one("fullpop.drain");

    // Reset mid-frame with data queued and a flag set.
    send_frame(8'h42, good_par(8'h42), 1'b1, 11'h0, 1'b0, 1'b0);
    send_frame(8'h43, ~good_par(8'h43), 1'b1, 11'h0, 1'b0, 1'b0);
    check_state("rst.pre");
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    m_q.delete();
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    check_state("rst.mid");
    tick(2);
    reset       = 1'b0;
    ps2_data_in = 1'b1;
    tick(5);
    send_frame(8'h99, good_par(8'h99), 1'b1, 11'h0, 1'b0, 1'b0);
    check_state("rst.next");
    pop_one("rst.pop");

    // Randomized frames against the model.
    for (int it = 0; it < 30; it++) begin
      d    = 8'($urandom);
      par  = good_par(d);
      stop = 1'b1;
      if ($urandom_range(0, 6) == 0) par = ~par;
      if ($urandom_range(0, 8) == 0) stop = 1'b0;
      pop  = ($urandom_range(0, 4) == 0);
      gm   = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'h0;
      send_frame(d, par, stop, gm, pop, 1'b0);
      check_state("rnd");
      repeat ($urandom_range(0, 2)) pop_one("rnd.pop");
      if ($urandom_range(0, 5) == 0) begin
        clear_flags();
        check_state("rnd.clr");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Receive-only PS/2 keyboard/mouse port controller; one instance per connector (ps2a, ps2b) inside MAXI030Core. It recovers frames from the bidirectional PS/2 clock and data pins and buffers received bytes in a small FIFO. The FIFO head is exposed to the 8-bit register read path, and its level drives the `ps2_irq` input of the interrupt priority encoder. The core keeps the pin outputs released (driven high, open-collector); this block only observes the pins.

## Interface

Parameters:
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, 2..16.
- `TIMEOUT`, 16'd40000: clock cycles without a PS/2 clock falling edge, while mid-frame, before the frame is abandoned.

Ports:
- `clock` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `ps2_clock_in` input 1: raw PS/2 clock pin, asynchronous to `clock`.
- `ps2_data_in` input 1: raw PS/2 data pin, asynchronous to `clock`.
- `read_strobe` input 1: one-cycle pop request, raised by the data-register read decode.
- `flush` input 1: one-cycle request to empty the FIFO.
- `status_clear` input 1: one-cycle request to clear the sticky error flags.
- `rx_data` output 8: FIFO head (show-ahead); 8'h00 when the FIFO is empty.
- `rx_valid` output 1: FIFO is not empty.
- `parity_error` output 1: sticky flag.
- `framing_error` output 1: sticky flag; covers a bad stop bit and a timeout.
- `overflow` output 1: sticky flag; a good frame was dropped because the FIFO was full.
- `irq` output 1: equals `rx_valid`; gating is done by `ints_enabled` in the core.

## Operation

Input conditioning:
- Each pin passes through a 2-flop synchroniser.
- The synchronised clock feeds a glitch filter. The filtered clock changes value only after 4 consecutive identical synchronised samples. The filtered clock resets to 1.
- A "sample event" is the cycle in which the filtered clock goes from 1 to 0. The synchronised data bit is captured in that cycle.

Frame FSM. The frame is 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1). States are IDLE, DATA, PARITY and STOP; a 3-bit counter tracks the data bits.
- IDLE: on a sample event with data 0, go to DATA with the counter at 0. A start bit of 1 is ignored and the FSM stays in IDLE.
- DATA: on each sample event, shift the bit into the shift register at position `counter` and increment the counter. After the 8th bit, go to PARITY.
- PARITY: capture the parity bit and go to STOP.
- STOP: on the sample event:
  - Stop bit is 1 and the XOR of the 8 data bits plus parity is 1: push the byte.
  - Parity is bad: discard the byte and set `parity_error`. Parity is checked first.
  - Parity is good but the stop bit is 0: discard the byte and set `framing_error`.
  - In every case, return to IDLE.
- Timeout: a 16-bit counter clears on every sample event and on entry to IDLE. It increments while the FSM is not in IDLE. When it reaches `TIMEOUT`, return to IDLE, discard the partial byte and set `framing_error`.

FIFO:
- Circular buffer with read and write pointers and a count of width clog2(`FIFO_DEPTH`)+1; both pointers wrap modulo `FIFO_DEPTH`.
- Push into a full FIFO with no pop in the same cycle: the byte is dropped and `overflow` is set.
- `read_strobe` while empty is ignored; the pointers do not move.
- Push and pop in the same cycle: both take effect and the count is unchanged. This also applies when the FIFO is full, in which case `overflow` is not set.
- `flush` zeroes both pointers and the count. If a push lands in the same cycle as `flush`, the flush wins and the byte is lost.

Sticky flags:
- `status_clear` clears all three flags.
- If a flag is set in the same cycle as `status_clear`, the set wins.

## Timing

- Reset, asynchronous: FSM goes to IDLE; pointers and count to 0; all flags to 0; `rx_valid`/`irq` to 0; `rx_data` to 8'h00; filtered clock and both synchronisers to 1.
- Reset mid-frame abandons the frame without setting any flag.
- Pin fall to sample event: 5 or 6 cycles (2 synchroniser stages plus 4 filter samples, depending on sampling phase). A low pulse of 3 cycles or fewer on the PS/2 clock never produces a sample event.
- Stop-bit sample event in cycle S: the write is committed at the end of S, so `rx_valid`, `irq` and `rx_data` are updated in S+1.
- Pop at cycle P: `rx_data` shows the next entry (or 8'h00 if the FIFO is now empty) and `rx_valid` updates in P+1.
- No handshake back to the PS/2 device: the block never inhibits the device clock.

## Test plan

- Send a frame with data 0x1C, parity 0, stop 1 (PS/2 clock period 80 µs) -> `rx_valid`=`irq`=1 and `rx_data`=0x1C one cycle after the stop sample event; then pulse `read_strobe` -> `rx_valid`=0 and `rx_data`=0x00.
- Send 0x1C with parity 1 -> no push, `parity_error`=1. Then send 0xF0 with stop bit 0 -> no push, `framing_error`=1. Then pulse `status_clear` -> both flags 0.
- With `FIFO_DEPTH`=8, send bytes 0x01..0x09 without popping -> count 8, `overflow`=1. Pop 8 times -> bytes 0x01..0x08 in order, 0x09 absent. Repeat 0x0A..0x11 to check pointer wrap.
- Inject 3-cycle low glitches on `ps2_clock_in` mid-frame -> the byte is unaffected. Inject a 3-cycle glitch while idle with data=0 -> no frame starts.
- Send start + 4 data bits, then hold the clock high for `TIMEOUT` cycles -> `framing_error`=1 and the FSM is back in IDLE; the next complete frame 0x5A is received correctly.
- With the FIFO full, land `read_strobe` on the push cycle -> the new byte is stored, `overflow` stays 0, count stays 8. Assert `reset` mid-frame -> all outputs take their reset values immediately; the next frame is received normally.
